// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S / TDM receive path: serial alignment modes,
// sync FSM encodings and a constant clog2 for parameter sizing.
package i2s_pkg;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_CAPTURE = 1'b1
  } sync_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO for tagged sample words. The head entry is held in a register
// so the read port stays stable (and keeps its last value) when the FIFO runs empty.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("i2s_sample_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q;
  logic [PW-1:0]    wr_q, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_s, rd_s;

  always_comb begin
    rd_s = pop_i & (cnt_q != '0);
    wr_s = push_i & ((cnt_q != DEPTH_C) | rd_s);
    rd_d = rd_s ? rd_q + PW'(1) : rd_q;
    case ({wr_s, rd_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_s) mem_q[wr_q] <= wdata_i;
  end

  // A word written into an empty (or just-emptied) FIFO goes straight to the head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wr_q  <= wr_s ? wr_q + PW'(1) : wr_q;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (wr_s && ((cnt_q == '0) || ((cnt_q == CW'(1)) && rd_s))) begin
        head_q <= wdata_i;
      end else if (cnt_d != '0) begin
        head_q <= mem_q[rd_d];
      end
    end
  end

  assign rdata_o = head_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);

endmodule

// File: rtl/i2s_rx_tdm.sv
// I2S / left-justified receiver with stereo or TDM framing; deserialised words are
// tagged with their slot index and queued for a VALID/READY consumer.
module i2s_rx_tdm
  import i2s_pkg::*;
#(
  parameter  int SAMPLE_WIDTH = 24,
  parameter  int SLOT_WIDTH   = 32,
  parameter  int NUM_CHANNELS = 2,
  parameter  int FIFO_DEPTH   = 8,
  localparam int CH_W = (clog2(NUM_CHANNELS) < 1) ? 1 : clog2(NUM_CHANNELS)
) (
  input  logic                    BCLK,
  input  logic                    RST,
  input  logic                    LRCLK,
  input  logic                    SDATA,
  input  logic                    MODE,
  output logic [SAMPLE_WIDTH-1:0] SAMPLE_DATA,
  output logic [CH_W-1:0]         SAMPLE_CHANNEL,
  output logic                    SAMPLE_VALID,
  input  logic                    SAMPLE_READY,
  output logic                    SYNCED,
  output logic                    OVERFLOW,
  output logic                    FRAME_ERROR,
  input  logic                    ERR_CLEAR
);

  if (SLOT_WIDTH < SAMPLE_WIDTH) begin : g_bad_slot
    $error("i2s_rx_tdm: SLOT_WIDTH must be >= SAMPLE_WIDTH");
  end

  localparam int CNT_W = clog2(SLOT_WIDTH + 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT_C  = CNT_W'(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] SAMPLE_LAST_C = CNT_W'(SAMPLE_WIDTH - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST_C   = CNT_W'(SLOT_WIDTH - 1);
  localparam logic [CH_W-1:0]  LAST_CH_C     = CH_W'(NUM_CHANNELS - 1);
  localparam bit               STEREO_C      = (NUM_CHANNELS == 2);

  sync_state_e             state_q;
  logic                    lr_d_q, lr_ok_q, edge_q, idle_q, done_q;
  logic                    overflow_q, frame_err_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [CH_W-1:0]         slot_q, done_ch_q;
  logic [SAMPLE_WIDTH-1:0] shift_q;

  logic                    edge_s, start_raw_s, rise_s, start_s, early_s;
  logic                    pop_s, drop_s, empty_s, full_s;
  logic [CH_W-1:0]         start_ch_s;
  logic [SAMPLE_WIDTH-1:0] shift_d;
  logic [CH_W+SAMPLE_WIDTH-1:0] head_s;

  // lr_ok_q masks the first cycle after reset so a high LRCLK is not seen as an edge.
  always_comb begin
    edge_s      = lr_ok_q & (LRCLK ^ lr_d_q);
    start_raw_s = (MODE == MODE_LJ) ? edge_s : edge_q;
    rise_s      = (MODE == MODE_LJ) ? LRCLK : lr_d_q;
    start_s     = STEREO_C ? start_raw_s : (start_raw_s & rise_s);
    start_ch_s  = (STEREO_C && rise_s) ? CH_W'(1) : '0;
    early_s     = start_s & (state_q == ST_CAPTURE) & ~idle_q & (bit_cnt_q < SAMPLE_CNT_C);
    shift_d     = SAMPLE_WIDTH'({shift_q, SDATA});
    pop_s       = ~empty_s & SAMPLE_READY;
    drop_s      = done_q & full_s & ~pop_s;
  end

  always_ff @(posedge BCLK) begin
    if (RST) begin
      state_q     <= ST_HUNT;
      lr_d_q      <= 1'b0;
      lr_ok_q     <= 1'b0;
      edge_q      <= 1'b0;
      idle_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      bit_cnt_q   <= '0;
      slot_q      <= '0;
      done_ch_q   <= '0;
      shift_q     <= '0;
    end else begin
      lr_d_q      <= LRCLK;
      lr_ok_q     <= 1'b1;
      edge_q      <= edge_s;
      done_q      <= 1'b0;
      overflow_q  <= drop_s | (overflow_q & ~ERR_CLEAR);
      frame_err_q <= early_s | (frame_err_q & ~ERR_CLEAR);
      if (start_s) begin
        state_q   <= ST_CAPTURE;
        slot_q    <= start_ch_s;
        done_ch_q <= start_ch_s;
        shift_q   <= shift_d;
        bit_cnt_q <= CNT_W'(1);
        idle_q    <= 1'b0;
        done_q    <= (SAMPLE_WIDTH == 1);
      end else if ((state_q == ST_CAPTURE) && !idle_q) begin
        if (bit_cnt_q < SAMPLE_CNT_C) shift_q <= shift_d;
        if (bit_cnt_q == SAMPLE_LAST_C) begin
          done_q    <= 1'b1;
          done_ch_q <= slot_q;
        end
        // Stereo waits for the next LRCLK edge; TDM walks the slots, then idles to frame end.
        if (bit_cnt_q == SLOT_LAST_C) begin
          bit_cnt_q <= '0;
          if (STEREO_C || (slot_q == LAST_CH_C)) idle_q <= 1'b1;
          else slot_q <= slot_q + CH_W'(1);
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  i2s_sample_fifo #(
    .WIDTH(CH_W + SAMPLE_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (BCLK),
    .rst_i  (RST),
    .push_i (done_q),
    .wdata_i({done_ch_q, shift_q}),
    .pop_i  (pop_s),
    .rdata_o(head_s),
    .empty_o(empty_s),
    .full_o (full_s)
  );

  assign SAMPLE_DATA    = head_s[SAMPLE_WIDTH-1:0];
  assign SAMPLE_CHANNEL = head_s[CH_W+SAMPLE_WIDTH-1 -: CH_W];
  assign SAMPLE_VALID   = ~empty_s;
  assign SYNCED         = (state_q == ST_CAPTURE);
  assign OVERFLOW       = overflow_q;
  assign FRAME_ERROR    = frame_err_q;

endmodule

// File: tb/tb_i2s_rx_tdm.sv
// Directed bench: a stereo instance (24/32, depth 8) and an 8-slot TDM instance.
module tb_i2s_rx_tdm;

  logic        bclk = 1'b0;
  logic        rst, lrclk, sdata, mode, ready, err_clear;
  logic [23:0] s_data;
  logic        s_ch, s_valid, synced, ovf, ferr;
  logic        lrclk_t, sdata_t;
  logic [23:0] t_data;
  logic [2:0]  t_ch;
  logic        t_valid, t_synced, t_ovf, t_ferr;

  int n_checks = 0;
  int n_errors = 0;
  logic [26:0] got_q[$];
  logic [26:0] got_t[$];
  logic [26:0] exp_q[$];

  always #5 bclk = ~bclk;

  i2s_rx_tdm dut (
    .BCLK(bclk), .RST(rst), .LRCLK(lrclk), .SDATA(sdata), .MODE(mode),
    .SAMPLE_DATA(s_data), .SAMPLE_CHANNEL(s_ch), .SAMPLE_VALID(s_valid),
    .SAMPLE_READY(ready), .SYNCED(synced), .OVERFLOW(ovf),
    .FRAME_ERROR(ferr), .ERR_CLEAR(err_clear)
  );

  i2s_rx_tdm #(.NUM_CHANNELS(8)) dut_tdm (
    .BCLK(bclk), .RST(rst), .LRCLK(lrclk_t), .SDATA(sdata_t), .MODE(mode),
    .SAMPLE_DATA(t_data), .SAMPLE_CHANNEL(t_ch), .SAMPLE_VALID(t_valid),
    .SAMPLE_READY(1'b1), .SYNCED(t_synced), .OVERFLOW(t_ovf),
    .FRAME_ERROR(t_ferr), .ERR_CLEAR(err_clear)
  );

  // Record every accepted word; the handshake completes on the following rising edge.
  always @(negedge bclk) begin
    if (s_valid && ready) got_q.push_back({2'b00, s_ch, s_data});
    if (t_valid) got_t.push_back({t_ch, t_data});
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [26:0] got[$], input logic [26:0] exp[$]);
    chk_eq({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; (i < exp.size()) && (i < got.size()); i++)
      chk_eq($sformatf("%s_word%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic do_reset(input logic lvl, input logic m);
    rst = 1'b1; lrclk = lvl; sdata = 1'b0; lrclk_t = 1'b0; sdata_t = 1'b0; mode = m;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  // One stereo slot: word MSB-first starting dly cycles after the LRCLK level change.
  task automatic drive_slot(input logic lvl, input logic [23:0] word, input int dly,
                            input int ncyc, input bit chk_v, input string tag);
    for (int i = 0; i < ncyc; i++) begin
      int j;
      j = i - dly;
      lrclk = lvl;
      sdata = ((j >= 0) && (j < 24)) ? word[23-j] : 1'b0;
      tick();
      if (chk_v && (i == 23 + dly)) chk_eq({tag, "_valid_at_lsb"}, s_valid, 1'b0);
      if (chk_v && (i == 24 + dly)) chk_eq({tag, "_valid_after"}, s_valid, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; lrclk = 1'b1; sdata = 1'b0; mode = 1'b0; ready = 1'b1;
    err_clear = 1'b0; lrclk_t = 1'b0; sdata_t = 1'b0;
    repeat (3) tick();
    chk_eq("rst_valid", s_valid, 1'b0);
    chk_eq("rst_synced", synced, 1'b0);
    chk_eq("rst_ovf", ovf, 1'b0);
    chk_eq("rst_ferr", ferr, 1'b0);
    chk_eq("rst_data", s_data, 24'h000000);
    chk_eq("rst_tdm_valid", t_valid, 1'b0);

    // 1: stereo I2S
    do_reset(1'b1, 1'b0);
    chk_eq("t1_hunt", synced, 1'b0);
    drive_slot(1'b0, 24'hA5A5A5, 1, 32, 1'b1, "t1_l");
    drive_slot(1'b1, 24'h3C3C3C, 1, 32, 1'b1, "t1_r");
    repeat (4) tick();
    chk_eq("t1_synced", synced, 1'b1);
    exp_q.push_back(27'h0A5A5A5); exp_q.push_back(27'h13C3C3C);
    chk_q("t1", got_q, exp_q);

    // 2: left-justified, then I2S-aligned data captured one bit early
    do_reset(1'b1, 1'b1);
    drive_slot(1'b0, 24'hA5A5A5, 0, 32, 1'b1, "t2_l");
    drive_slot(1'b1, 24'h3C3C3C, 0, 32, 1'b1, "t2_r");
    drive_slot(1'b0, 24'hA5A5A5, 1, 32, 1'b0, "t2_l2");
    drive_slot(1'b1, 24'h3C3C3C, 1, 32, 1'b0, "t2_r2");
    repeat (4) tick();
    exp_q.push_back(27'h0A5A5A5); exp_q.push_back(27'h13C3C3C);
    exp_q.push_back(27'h052D2D2); exp_q.push_back(27'h11E1E1E);
    chk_q("t2", got_q, exp_q);

    // 3: TDM, 8 slots, one-cycle frame pulse; a ninth slot of data must be ignored
    do_reset(1'b1, 1'b0);
    for (int t = 0; t < 300; t++) begin
      int s, j;
      logic [23:0] w;
      lrclk_t = (t == 0);
      s = (t - 1) / 32;
      j = (t - 1) % 32;
      w = (s < 8) ? 24'(s + 1) : 24'hFFFFFF;
      sdata_t = ((t >= 1) && (j < 24)) ? w[23-j] : 1'b0;
      tick();
    end
    chk_eq("t3_synced", t_synced, 1'b1);
    chk_eq("t3_ferr", t_ferr, 1'b0);
    chk_eq("t3_ovf", t_ovf, 1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 24'(i + 1)});
    chk_q("t3", got_t, exp_q);

    // 4: overflow with READY low, drain, clear
    do_reset(1'b1, 1'b0);
    ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      drive_slot(1'b0, 24'h100000 + 24'(2 * f + 1), 1, 32, 1'b0, "t4_l");
      drive_slot(1'b1, 24'h100000 + 24'(2 * f + 2), 1, 32, 1'b0, "t4_r");
    end
    chk_eq("t4_ovf_at_full", ovf, 1'b0);
    chk_eq("t4_valid_full", s_valid, 1'b1);
    drive_slot(1'b0, 24'h100009, 1, 32, 1'b0, "t4_l9");
    chk_eq("t4_ovf_word9", ovf, 1'b1);
    drive_slot(1'b1, 24'h10000A, 1, 32, 1'b0, "t4_r10");
    ready = 1'b1;
    repeat (12) tick();
    for (int k = 1; k <= 8; k++) exp_q.push_back({2'b00, 1'(k % 2 == 0), 24'h100000 + 24'(k)});
    chk_q("t4", got_q, exp_q);
    chk_eq("t4_valid_drained", s_valid, 1'b0);
    chk_eq("t4_data_hold", s_data, 24'h100008);
    chk_eq("t4_ovf_sticky", ovf, 1'b1);
    err_clear = 1'b1; tick(); err_clear = 1'b0; tick();
    chk_eq("t4_ovf_cleared", ovf, 1'b0);

    // 5: left slot truncated after 10 bits
    do_reset(1'b1, 1'b0);
    drive_slot(1'b0, 24'hFFFFFF, 1, 11, 1'b0, "t5_l");
    drive_slot(1'b1, 24'h3C3C3C, 1, 32, 1'b0, "t5_r");
    repeat (4) tick();
    chk_eq("t5_ferr", ferr, 1'b1);
    exp_q.push_back(27'h13C3C3C);
    chk_q("t5", got_q, exp_q);
    err_clear = 1'b1; tick(); err_clear = 1'b0; tick();
    chk_eq("t5_ferr_cleared", ferr, 1'b0);

    // 6: reset mid-slot with three words queued
    do_reset(1'b1, 1'b0);
    ready = 1'b0;
    drive_slot(1'b0, 24'h111111, 1, 32, 1'b0, "t6_l");
    drive_slot(1'b1, 24'h222222, 1, 32, 1'b0, "t6_r");
    drive_slot(1'b0, 24'h333333, 1, 32, 1'b0, "t6_l2");
    drive_slot(1'b1, 24'h777777, 1, 10, 1'b0, "t6_r2");
    chk_eq("t6_valid_queued", s_valid, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_eq("t6_valid_rst", s_valid, 1'b0);
    chk_eq("t6_synced_rst", synced, 1'b0);
    ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      sdata = 1'(i % 2);
      tick();
    end
    chk_eq("t6_hunt", synced, 1'b0);
    chk_eq("t6_no_word", s_valid, 1'b0);
    drive_slot(1'b0, 24'h123456, 1, 32, 1'b0, "t6_l3");
    drive_slot(1'b1, 24'h654321, 1, 32, 1'b0, "t6_r3");
    repeat (4) tick();
    exp_q.push_back(27'h0123456); exp_q.push_back(27'h1654321);
    chk_q("t6", got_q, exp_q);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
